// File: rtl/iomem_timer.sv
// Purpose: memory-mapped 32-bit prescaled timer with compare-match level IRQ on the iomem bus.
// Latency: one-cycle ack; read data and write effects are registered at the accepting edge.
// Backpressure: none; each request in the 256-byte window is acked exactly once, others ignored.
// Build option: define IOMEM_TIMER_AUTORELOAD_EN for periodic reload; otherwise one-shot.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter logic [15:0] RESET_PRESCALE = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    localparam logic [5:0] SEL_CTRL     = 6'h00;
    localparam logic [5:0] SEL_PRESCALE = 6'h01;
    localparam logic [5:0] SEL_COUNT    = 6'h02;
    localparam logic [5:0] SEL_COMPARE  = 6'h03;
    localparam logic [5:0] SEL_STATUS   = 6'h04;

    logic        ctrl_en;
    logic        ctrl_irq_en;
    logic [15:0] prescale;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic [15:0] pcnt;

    logic        hit;
    logic        req;
    logic        wr;
    logic        rd;
    logic [5:0]  reg_sel;
    logic        tick;
    logic        match_evt;
    logic        pcnt_clr;
    logic [31:0] rd_mux;

    // Byte address bits below the word are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^iomem_addr[1:0];

    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    assign hit     = (iomem_addr[31:8] == BASE_ADDR[31:8]);
    // The !ready term keeps a held valid from being accepted twice.
    assign req     = iomem_valid & hit & ~iomem_ready;
    assign wr      = req & (|iomem_wstrb);
    assign rd      = req & ~(|iomem_wstrb);
    assign reg_sel = iomem_addr[7:2];

    assign tick      = ctrl_en && (pcnt == prescale);
    assign match_evt = tick && (count == compare);

    // Any prescale rewrite, or software dropping EN, restarts the prescaler phase.
    assign pcnt_clr = (wr && reg_sel == SEL_PRESCALE) ||
                      (wr && reg_sel == SEL_CTRL && iomem_wstrb[0] && !iomem_wdata[0]);

    assign irq = match & ctrl_irq_en;

    // Read multiplexer; unmapped offsets read as zero.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            SEL_CTRL:     rd_mux = {30'd0, ctrl_irq_en, ctrl_en};
            SEL_PRESCALE: rd_mux = {16'd0, prescale};
            SEL_COUNT:    rd_mux = count;
            SEL_COMPARE:  rd_mux = compare;
            SEL_STATUS:   rd_mux = {31'd0, match};
            default:      rd_mux = '0;
        endcase
    end

    // Bus handshake: single-cycle ack, rdata zero except on read acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= req;
            iomem_rdata <= rd ? rd_mux : 32'd0;
        end
    end

    // Control and configuration registers; a bus write of EN wins over one-shot auto-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            prescale    <= RESET_PRESCALE;
            compare     <= 32'hFFFF_FFFF;
        end else begin
            if (wr && reg_sel == SEL_CTRL && iomem_wstrb[0]) begin
                ctrl_en     <= iomem_wdata[0];
                ctrl_irq_en <= iomem_wdata[1];
            end
`ifndef IOMEM_TIMER_AUTORELOAD_EN
            else if (match_evt) begin
                ctrl_en <= 1'b0;
            end
`endif
            if (wr && reg_sel == SEL_PRESCALE) begin
                if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
                if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
            end
            if (wr && reg_sel == SEL_COMPARE) begin
                compare <= merge32(compare, iomem_wdata, iomem_wstrb);
            end
        end
    end

    // Prescaler: counts 0..PRESCALE while enabled, one tick per wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (pcnt_clr || tick) begin
            pcnt <= '0;
        end else if (ctrl_en) begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Counter: bus write wins; on a match it reloads (periodic) or holds (one-shot).
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (wr && reg_sel == SEL_COUNT) begin
            count <= merge32(count, iomem_wdata, iomem_wstrb);
        end
`ifdef IOMEM_TIMER_AUTORELOAD_EN
        else if (match_evt) begin
            count <= '0;
        end
`endif
        else if (tick && !match_evt) begin
            count <= count + 32'd1;
        end
    end

    // Match flag: set by a match event, which wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            match <= 1'b0;
        end else if (match_evt) begin
            match <= 1'b1;
        end else if (wr && reg_sel == SEL_STATUS && iomem_wstrb[0] && iomem_wdata[0]) begin
            match <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iomem_timer.sv
// Self-checking bench for iomem_timer: register table, then timing sequences.
// Bus acks are scored against a queue of expected read data.
// Works for both the one-shot and the auto-reload build.
module tb_iomem_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];
    logic        prev_ready = 1'b0;

    typedef struct {
        logic [7:0]  off;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    iomem_timer #(.BASE_ADDR(BASE), .RESET_PRESCALE(16'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack pops one expected rdata; idle cycles must show rdata=0.
    always @(posedge clk) begin
        #1;
        if (iomem_ready) begin
            check("ready_width", {31'd0, prev_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ack with rdata %h, no request pending", iomem_rdata);
            end else begin
                check("rdata", iomem_rdata, exp_q.pop_front());
            end
        end else begin
            check("rdata_idle", iomem_rdata, 32'd0);
        end
        prev_ready = iomem_ready;
    end

    task automatic bus(input logic [7:0] off, input logic [3:0] strb,
                       input logic [31:0] wdata, input logic [31:0] exp);
        int   n;
        logic busy;
        @(negedge clk);
        busy        = iomem_ready;
        iomem_valid = 1'b1;
        iomem_addr  = BASE + {24'd0, off};
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        exp_q.push_back(strb == 4'd0 ? exp : 32'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!iomem_ready && n < 20);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        if (!iomem_ready) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after %0d cycles, required within 2", n);
        end else begin
            check("ack_latency", n, busy ? 32'd2 : 32'd1);
        end
    endtask

    task automatic wait_irq(output int t);
        int n = 0;
        while (!irq && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        t = cyc;
        if (!irq) begin
            checks++;
            errors++;
            $display("FAIL irq_timeout: got irq=0 after %0d cycles, required irq=1", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2;
        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        iomem_addr  = '0;
        iomem_wdata = '0;

        vecs.push_back('{8'h00, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{8'h04, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{8'h08, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{8'h0C, 4'h0, 32'h0,         32'hFFFF_FFFF});
        vecs.push_back('{8'h10, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{8'h20, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{8'h24, 4'hF, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{8'h24, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{8'h04, 4'hF, 32'hFFFF_0003, 32'h0});
        vecs.push_back('{8'h04, 4'h0, 32'h0,         32'h3});
        vecs.push_back('{8'h0C, 4'hF, 32'h0000_0004, 32'h0});
        vecs.push_back('{8'h0F, 4'h0, 32'h0,         32'h4});
        vecs.push_back('{8'h00, 4'hF, 32'hFFFF_FFFE, 32'h0});
        vecs.push_back('{8'h00, 4'h0, 32'h0,         32'h2});
        vecs.push_back('{8'h00, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{8'h08, 4'hF, 32'h1122_3344, 32'h0});
        vecs.push_back('{8'h08, 4'h2, 32'h0000_AB00, 32'h0});
        vecs.push_back('{8'h08, 4'h0, 32'h0,         32'h1122_AB44});
        vecs.push_back('{8'h08, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{8'h10, 4'h0, 32'h0,         32'h0});

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, iomem_ready}, 32'd0);
        check("reset_rdata", iomem_rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) bus(vecs[i].off, vecs[i].strb, vecs[i].wdata, vecs[i].exp);

        // PRESCALE=3, COMPARE=4: first irq 20 cycles after EN lands.
        bus(8'h00, 4'hF, 32'h3, 32'h0);
        t0 = cyc;
        wait_irq(t1);
        check("irq_rise_delay", t1 - t0, 32'd20);
`ifdef IOMEM_TIMER_AUTORELOAD_EN
        bus(8'h08, 4'h0, 32'h0, 32'h0);
        bus(8'h10, 4'hF, 32'h1, 32'h0);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        wait_irq(t2);
        check("irq_period", t2 - t1, 32'd20);
        bus(8'h00, 4'hF, 32'h0, 32'h0);
`else
        t2 = t1;
        bus(8'h08, 4'h0, 32'h0, 32'h4);
        bus(8'h00, 4'h0, 32'h0, 32'h2);
`endif
        // STATUS write without lane 0 must not clear MATCH.
        bus(8'h10, 4'h2, 32'h1, 32'h0);
        bus(8'h10, 4'h0, 32'h0, 32'h1);
        bus(8'h10, 4'hF, 32'h1, 32'h0);
        check("irq_after_clear", {31'd0, irq}, 32'd0);
        bus(8'h00, 4'hF, 32'h0, 32'h0);

        // W1C lands in the same cycle as the match tick: MATCH must stay set.
        bus(8'h04, 4'hF, 32'h1, 32'h0);
        bus(8'h0C, 4'hF, 32'h7, 32'h0);
        bus(8'h08, 4'hF, 32'h7, 32'h0);
        bus(8'h00, 4'hF, 32'h3, 32'h0);
        bus(8'h10, 4'hF, 32'h1, 32'h0);
        check("irq_set_beats_w1c", {31'd0, irq}, 32'd1);
        bus(8'h10, 4'h0, 32'h0, 32'h1);
        bus(8'h00, 4'hF, 32'h0, 32'h0);
        bus(8'h10, 4'hF, 32'h1, 32'h0);

        // COUNT wraps from FFFF_FFFF to 0 without MATCH; match 6 ticks later.
        bus(8'h04, 4'hF, 32'h0, 32'h0);
        bus(8'h0C, 4'hF, 32'h5, 32'h0);
        bus(8'h08, 4'hF, 32'hFFFF_FFFF, 32'h0);
        bus(8'h00, 4'hF, 32'h3, 32'h0);
        t0 = cyc;
        wait_irq(t1);
        check("wrap_then_match", t1 - t0, 32'd7);
        bus(8'h00, 4'hF, 32'h0, 32'h0);
        bus(8'h10, 4'hF, 32'h1, 32'h0);

        // Outside the window: never acknowledged, write has no effect.
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h100;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("outside_no_ready", {31'd0, iomem_ready}, 32'd0);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        bus(8'h00, 4'h0, 32'h0, 32'h0);

        // Reset during a pending request drops the ack and restores defaults.
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h0C;
        iomem_wstrb = 4'd0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        check("reset_drops_ack", {31'd0, iomem_ready}, 32'd0);
        @(negedge clk);
        iomem_valid = 1'b0;
        reset       = 1'b0;
        bus(8'h0C, 4'h0, 32'h0, 32'hFFFF_FFFF);
        bus(8'h04, 4'h0, 32'h0, 32'h0);
        check("irq_after_reset", {31'd0, irq}, 32'd0);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
